// File: rtl/btn_event_unit.sv
// Multi-channel push-button conditioner: synchroniser, debounce, edge pulse, auto-repeat.
// Latency: raw change to btn_level/btn_pulse is SYNC_STAGES+DB_CYCLES clk edges; repeats follow from the hold counter.
// Backpressure: none. Pulses are single-cycle events and are not held for a consumer.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   raw_btn[N_CH]         asynchronous active-high button inputs
//   edge_mode[2*N_CH]     per channel {fall_en, rise_en}
//   repeat_en[N_CH]       per-channel auto-repeat enable
//   btn_level[N_CH]       debounced level
//   btn_pulse[N_CH]       one-cycle event (edge or repeat)
//   btn_repeat[N_CH]      qualifies btn_pulse as an auto-repeat
//   event_any             OR of btn_pulse
module btn_event_unit #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   raw_btn,
  input  logic [2*N_CH-1:0] edge_mode,
  input  logic [N_CH-1:0]   repeat_en,
  output logic [N_CH-1:0]   btn_level,
  output logic [N_CH-1:0]   btn_pulse,
  output logic [N_CH-1:0]   btn_repeat,
  output logic              event_any
);

  localparam int DB_W     = $clog2(DB_CYCLES) + 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_SAT    = DB_W'(DB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_DLY  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] HOLD_PER  = HOLD_W'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_MAX);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   rep_phase_q, rep_phase_d;  // 0: waiting initial delay, 1: periodic
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   repeat_q, repeat_d;
    logic                   sync_out;
    logic                   rise_en, fall_en;
    logic                   level_chg;
    logic                   rep_active;
    logic                   rep_fire;
    logic [HOLD_W-1:0]      hold_tgt;

    always_comb begin
      sync_d      = {sync_q[SYNC_STAGES-2:0], raw_btn[i]};
      sync_out    = sync_q[SYNC_STAGES-1];
      rise_en     = edge_mode[2*i];
      fall_en     = edge_mode[2*i+1];
      level_d     = level_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      rep_phase_d = rep_phase_q;

      // Level is accepted on the edge where the mismatch has already been seen DB_CYCLES times.
      level_chg = (sync_out != level_q) && (db_cnt_q == DB_LAST);
      if (sync_out == level_q) begin
        db_cnt_d = '0;
      end else if (level_chg) begin
        level_d  = sync_out;
        db_cnt_d = '0;
      end else if (db_cnt_q != DB_SAT) begin
        db_cnt_d = db_cnt_q + 1'b1;
      end

      // The rise update edge itself sees level_q=0, so the hold counter starts from zero there.
      rep_active = level_q && rise_en && repeat_en[i];
      hold_tgt   = rep_phase_q ? HOLD_PER : HOLD_DLY;
      // A release landing on a repeat edge wins: no repeat on the level-change edge.
      rep_fire   = rep_active && !level_chg && (hold_cnt_q == hold_tgt);

      if (!rep_active || level_chg) begin
        hold_cnt_d  = '0;
        rep_phase_d = 1'b0;
      end else if (rep_fire) begin
        hold_cnt_d  = '0;
        rep_phase_d = 1'b1;
      end else if (hold_cnt_q != HOLD_SAT) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end

      pulse_d  = (level_chg && (sync_out ? rise_en : fall_en)) || rep_fire;
      repeat_d = rep_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q      <= '0;
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        rep_phase_q <= 1'b0;
        level_q     <= 1'b0;
        pulse_q     <= 1'b0;
        repeat_q    <= 1'b0;
      end else begin
        sync_q      <= sync_d;
        db_cnt_q    <= db_cnt_d;
        hold_cnt_q  <= hold_cnt_d;
        rep_phase_q <= rep_phase_d;
        level_q     <= level_d;
        pulse_q     <= pulse_d;
        repeat_q    <= repeat_d;
      end
    end

    assign btn_level[i]  = level_q;
    assign btn_pulse[i]  = pulse_q;
    assign btn_repeat[i] = repeat_q;
  end

  assign event_any = |btn_pulse;

endmodule

// File: tb/tb_btn_event_unit.sv
module tb_btn_event_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw_btn;
  logic [7:0] edge_mode;
  logic [3:0] repeat_en;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [3:0] btn_repeat;
  logic       event_any;

  int total = 0;
  int bad   = 0;

  btn_event_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_btn    (raw_btn),
    .edge_mode  (edge_mode),
    .repeat_en  (repeat_en),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_repeat (btn_repeat),
    .event_any  (event_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Steps n edges and checks no pulse occurred in that window.
  task automatic run_quiet(input int n, input string tag);
    logic [3:0] seen;
    seen = '0;
    for (int k = 0; k < n; k++) begin
      step();
      seen = seen | btn_pulse;
    end
    chk(tag, {4'h0, seen}, 8'h00);
  endtask

  initial begin
    rst_n     = 1'b0;
    raw_btn   = 4'h0;
    edge_mode = 8'h55;
    repeat_en = 4'h0;
    step();
    step();
    chk("rst_level", {4'h0, btn_level}, 8'h00);
    chk("rst_pulse", {4'h0, btn_pulse}, 8'h00);
    chk("rst_any",   {7'h0, event_any}, 8'h00);
    rst_n = 1'b1;
    step();

    // 1: basic press/release, mode 01 everywhere
    raw_btn = 4'h1;
    for (int k = 0; k < 5; k++) step();
    chk("t1_level_e5", {4'h0, btn_level}, 8'h00);
    step();
    chk("t1_level_e6", {4'h0, btn_level}, 8'h01);
    chk("t1_pulse_e6", {4'h0, btn_pulse}, 8'h01);
    chk("t1_any_e6",   {7'h0, event_any}, 8'h01);
    chk("t1_rep_e6",   {4'h0, btn_repeat}, 8'h00);
    step();
    chk("t1_pulse_e7", {4'h0, btn_pulse}, 8'h00);
    chk("t1_any_e7",   {7'h0, event_any}, 8'h00);
    raw_btn = 4'h0;
    run_quiet(5, "t1_rel_quiet");
    chk("t1_rel_level_e5", {4'h0, btn_level}, 8'h01);
    step();
    chk("t1_rel_level_e6", {4'h0, btn_level}, 8'h00);
    chk("t1_rel_pulse_e6", {4'h0, btn_pulse}, 8'h00);

    // 2: glitch shorter than debounce window, then exactly long enough
    raw_btn = 4'h1;
    step(); step(); step();
    raw_btn = 4'h0;
    run_quiet(10, "t2_glitch_pulse");
    chk("t2_glitch_level", {4'h0, btn_level}, 8'h00);
    raw_btn = 4'h1;
    step(); step(); step(); step();
    raw_btn = 4'h0;
    step();
    chk("t2_min_level_e5", {4'h0, btn_level}, 8'h00);
    step();
    chk("t2_min_level_e6", {4'h0, btn_level}, 8'h01);
    chk("t2_min_pulse_e6", {4'h0, btn_pulse}, 8'h01);
    for (int k = 0; k < 10; k++) step();
    chk("t2_min_level_back", {4'h0, btn_level}, 8'h00);

    // 3: ch1 fall-only
    edge_mode = 8'h59;
    raw_btn   = 4'h2;
    run_quiet(6, "t3_press_nopulse");
    chk("t3_press_level", {4'h0, btn_level}, 8'h02);
    step(); step(); step(); step();
    raw_btn = 4'h0;
    run_quiet(5, "t3_rel_quiet");
    step();
    chk("t3_rel_level", {4'h0, btn_level}, 8'h00);
    chk("t3_rel_pulse", {4'h0, btn_pulse}, 8'h02);
    step();
    chk("t3_rel_pulse_off", {4'h0, btn_pulse}, 8'h00);

    // 4: ch2 auto-repeat
    repeat_en = 4'h4;
    raw_btn   = 4'h4;
    for (int k = 0; k < 5; k++) step();
    step();
    chk("t4_T_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t4_T_rep",   {4'h0, btn_repeat}, 8'h00);
    run_quiet(7, "t4_delay_quiet");
    step();
    chk("t4_T8_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t4_T8_rep",   {4'h0, btn_repeat}, 8'h04);
    chk("t4_T8_any",   {7'h0, event_any},  8'h01);
    run_quiet(3, "t4_per1_quiet");
    step();
    chk("t4_T12_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t4_T12_rep",   {4'h0, btn_repeat}, 8'h04);
    run_quiet(3, "t4_per2_quiet");
    step();
    chk("t4_T16_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t4_T16_rep",   {4'h0, btn_repeat}, 8'h04);
    raw_btn = 4'h0;
    run_quiet(3, "t4_per3_quiet");
    step();
    chk("t4_T20_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t4_T20_rep",   {4'h0, btn_repeat}, 8'h04);
    step(); step();
    chk("t4_T22_level", {4'h0, btn_level}, 8'h00);
    chk("t4_T22_pulse", {4'h0, btn_pulse}, 8'h00);
    run_quiet(20, "t4_after_release");

    // 5: simultaneous press on ch0 and ch3
    repeat_en = 4'h0;
    raw_btn   = 4'h9;
    for (int k = 0; k < 5; k++) step();
    step();
    chk("t5_pulse", {4'h0, btn_pulse}, 8'h09);
    chk("t5_any",   {7'h0, event_any}, 8'h01);
    step();
    chk("t5_pulse_off", {4'h0, btn_pulse}, 8'h00);
    chk("t5_any_off",   {7'h0, event_any}, 8'h00);
    raw_btn = 4'h0;
    run_quiet(12, "t5_release_quiet");

    // 6: reset in the middle of auto-repeat, raw held
    repeat_en = 4'h4;
    raw_btn   = 4'h4;
    for (int k = 0; k < 5; k++) step();
    step();
    chk("t6_T_pulse", {4'h0, btn_pulse}, 8'h04);
    run_quiet(7, "t6_delay_quiet");
    step();
    chk("t6_T8_rep", {4'h0, btn_repeat}, 8'h04);
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_level", {4'h0, btn_level},  8'h00);
    chk("t6_rst_pulse", {4'h0, btn_pulse},  8'h00);
    chk("t6_rst_rep",   {4'h0, btn_repeat}, 8'h00);
    chk("t6_rst_any",   {7'h0, event_any},  8'h00);
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("t6_post_level_e5", {4'h0, btn_level}, 8'h00);
    step();
    chk("t6_post_level_e6", {4'h0, btn_level},  8'h04);
    chk("t6_post_pulse_e6", {4'h0, btn_pulse},  8'h04);
    chk("t6_post_rep_e6",   {4'h0, btn_repeat}, 8'h00);
    run_quiet(7, "t6_post_delay_quiet");
    step();
    chk("t6_post_T8_pulse", {4'h0, btn_pulse},  8'h04);
    chk("t6_post_T8_rep",   {4'h0, btn_repeat}, 8'h04);
    raw_btn = 4'h0;
    for (int k = 0; k < 20; k++) step();
    chk("t6_final_level", {4'h0, btn_level}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_event_unit.md
Name: btn_event_unit

Overview:
Multi-channel push-button conditioner for board inputs (KEY/SW). It replaces single-channel edge pulsing with a per-channel pipeline: synchroniser, debounce filter, configurable edge detection and optional auto-repeat. Outputs are single-cycle event pulses that feed the CPU control/step logic and memory-mapped input registers.

Parameters:
N_CH, 4, number of independent button channels
SYNC_STAGES, 2, flip-flop synchroniser depth per channel (>=2)
DB_CYCLES, 4, consecutive stable synchronised cycles required to accept a new level (>=1)
REPEAT_DELAY, 8, cycles from press pulse to first auto-repeat pulse (>=1)
REPEAT_PERIOD, 4, cycles between subsequent auto-repeat pulses (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
raw_btn  in  N_CH  asynchronous button inputs, active-high
edge_mode  in  2*N_CH  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
repeat_en  in  N_CH  per-channel auto-repeat enable
btn_level  out  N_CH  debounced level
btn_pulse  out  N_CH  one-cycle event pulse (edge or repeat)
btn_repeat  out  N_CH  high with btn_pulse when the pulse is an auto-repeat
event_any  out  1  OR of btn_pulse

Behaviour:
- Reset (async assert, sync-to-clk release): all sync flops, debounce counters, hold counters and outputs = 0.
- Channels fully independent; same logic replicated N_CH times.
- Synchroniser: SYNC_STAGES-deep shift chain; sync_out = last stage.
- Debounce: if sync_out == btn_level, counter <= 0. Otherwise counter increments; on the edge where counter == DB_CYCLES-1 and sync_out still differs, btn_level <= sync_out and counter <= 0.
- A raw change stable for fewer than DB_CYCLES synchronised cycles produces no level change and no pulse.
- Latency: counting the first clk edge that samples the new raw value as edge 1, btn_level and its edge pulse update on edge SYNC_STAGES+DB_CYCLES (default 6).
- Edge pulse: registered on the same edge as the btn_level update, high for exactly 1 cycle. A rise pulses if edge_mode bit0=1; a fall pulses if bit1=1. Mode 00: level still tracks, no pulses.
- edge_mode and repeat_en are sampled every cycle; a change affects only later events.
- Auto-repeat is active while btn_level=1, edge_mode bit0=1 and repeat_en=1.
  - The hold counter clears on the rise update edge.
  - First repeat pulse fires REPEAT_DELAY cycles after the press pulse; later ones fire every REPEAT_PERIOD cycles.
  - Repeat pulses assert btn_pulse and btn_repeat together for 1 cycle.
- Repeat inactive (level falls, repeat_en=0, or bit0=0): the hold counter clears immediately, with no pending pulse. Re-enabling mid-hold restarts the delay from that cycle.
- Release on the edge a repeat would fire: the repeat is suppressed. A fall pulse is emitted only if bit1=1, with btn_repeat=0.
- Never more than one pulse per channel per cycle.
- event_any: combinational OR of the registered btn_pulse vector, so it is asserted in the same cycle.
- Reset mid-operation clears all state.
  - After release with raw still high, the channel re-qualifies as a fresh press: level rises and a pulse fires after SYNC_STAGES+DB_CYCLES edges, per mode.
- Counter widths are $clog2 of their max value +1. Counters saturate and never wrap.

Test Plan:
1. Defaults, edge_mode=8'h55, raw_btn 0->4'h1 held -> btn_level[0]=1 and btn_pulse=4'h1 for 1 cycle on edge 6, event_any=1 that cycle; raw back to 0 -> btn_level[0]=0 on edge 6, no pulse.
2. raw_btn[0] high for 3 cycles then low -> btn_level and btn_pulse stay 0. High for 4 cycles -> level rises at edge 6 and pulse fires.
3. ch1 edge_mode=10, press 10 cycles then release -> btn_level[1] tracks both edges; btn_pulse[1] only on the release update edge.
4. ch2 mode=01, repeat_en[2]=1, hold 30 cycles, press pulse at cycle T -> pulses at T, T+8, T+12, T+16 ..., btn_repeat[2]=1 on all but T; release -> no further pulses.
5. ch0 and ch3 pressed in the same cycle, mode 01 -> btn_pulse=4'h9 in one cycle, event_any high for that one cycle.
6. Assert rst_n mid-repeat with raw_btn[2] held -> all outputs 0 immediately; after release, btn_level[2]=1 and a press pulse at edge 6, then repeats resume after 8 cycles.
